// File: rtl/mul_share_sched_pkg.sv
// Shared types and constants for the shared-multiplier scheduler.
package mul_share_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Cycles allowed in WAIT before the core is aborted.
  localparam int DEFAULT_TIMEOUT = 64;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_sched_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, wrapping modulo N_REQ.
module mul_share_sched_rr_grant
  import mul_share_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDW-1:0]   i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Pointer plus offset, folded back into 0..N_REQ-1 without a divider.
  function automatic int wrap_idx(input int ptr, input int off);
    int s;
    s = ptr + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_any && i_req_valid[wrap_idx(int'(i_rr_ptr), i)]) begin
        o_any                                 = 1'b1;
        o_idx                                 = IDW'(wrap_idx(int'(i_rr_ptr), i));
        o_grant[wrap_idx(int'(i_rr_ptr), i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one sequential multiplier core among N_REQ requesters: round-robin
// grant, launch, watchdog-guarded wait, tagged response.
module mul_share_sched
  import mul_share_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       mul_start,
  output logic                       mul_abort,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_product,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [id_width(N_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic                       rsp_err
);

  localparam int IDW = id_width(N_REQ);
  localparam int WDW = $clog2(TIMEOUT);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IDW-1:0]       r_rr_ptr;
  logic [WDW-1:0]       r_wdog;
  logic [IDW-1:0]       r_id;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic                 r_mul_start;
  logic                 r_rsp_valid;
  logic [2*WIDTH-1:0]   r_rsp_product;
  logic                 r_rsp_err;

  logic [N_REQ-1:0]     w_grant;
  logic [IDW-1:0]       w_grant_idx;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_timeout;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic [IDW-1:0]       w_ptr_nxt;

  mul_share_sched_rr_grant #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_grant (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_grant_idx),
    .o_any       (w_any)
  );

  // Next state and the single-cycle decisions taken in each state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Holding off the grant during reset keeps req_ready low while the
        // flops cannot capture the request.
        if (w_any && reset_n) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT;  // any mul_done here is stale
      ST_WAIT: begin
        // A done on the last watchdog cycle still counts as a completion.
        if (mul_done) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands of the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_idx == IDW'(N_REQ - 1)) ? '0 : w_grant_idx + IDW'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Capture the granted request, run the watchdog and build the response.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the datapath registers are cleared by reset too, so a stale ID or
    // product from before the reset can never appear on the outputs.
    if (!reset_n) begin
      r_rr_ptr      <= '0;
      r_wdog        <= '0;
      r_id          <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_start   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every register here sees
      // the pre-edge value of every other one, whatever the statement order.
      r_mul_start <= w_accept;

      if (w_accept) begin
        r_id     <= w_grant_idx;
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
        r_rr_ptr <= w_ptr_nxt;
      end

      if (r_state == ST_LAUNCH)    r_wdog <= '0;
      else if (r_state == ST_WAIT) r_wdog <= r_wdog + WDW'(1);

      if (w_done) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_product <= mul_product;
        r_rsp_err     <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_product <= '0;
        r_rsp_err     <= 1'b1;
      end else if (r_state == ST_RESP && rsp_ready) begin
        r_rsp_valid   <= 1'b0;
      end
    end
  end

  // Abort is decoded from the registered state and watchdog and is
  // suppressed by a same-cycle done, so a completion on the last cycle wins.
  assign mul_abort   = w_timeout;
  assign req_ready   = w_accept ? w_grant : '0;
  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_product = r_rsp_product;
  assign rsp_err     = r_rsp_err;

endmodule
